multicycle_ctrl_fsm: RTL



---
 rtl/multicycle_ctrl_fsm.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV64 datapath: fetch, decode,
// execute, memory and writeback, with traps on bad opcodes or stalled memory.
module multicycle_ctrl_fsm #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             branch,
    output logic             illegal,
    output logic             timeout,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_TRAP   = 4'd7
    } state_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             ill_q, ill_d;
    logic             to_q, to_d;
    logic             waiting, expire, kill;

    logic req_c, irw_c, pcw_c, src_c, mrd_c, mwr_c, m2r_c, rw_c, br_c;
    logic [1:0] aop_c;

    always_comb begin
        waiting = 1'b0;
        case (state_q)
            S_FETCH:            waiting = !imem_ready;
            S_MEM_RD, S_MEM_WR: waiting = !dmem_ready;
            default:            waiting = 1'b0;
        endcase
    end

    // Ready arriving on the last allowed cycle still completes the access.
    assign expire = waiting && (wait_q == WAIT_LAST);
    assign kill   = reset || expire;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = wait_q;
        ret_d   = ret_q;
        ill_d   = ill_q;
        to_d    = to_q;
        req_c   = 1'b0;
        irw_c   = 1'b0;
        pcw_c   = 1'b0;
        src_c   = 1'b0;
        aop_c   = 2'b00;
        mrd_c   = 1'b0;
        mwr_c   = 1'b0;
        m2r_c   = 1'b0;
        rw_c    = 1'b0;
        br_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (imem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                unique case (opcode)
                    OP_R, OP_I, OP_LD, OP_SD: state_d = S_EXEC;
                    OP_BEQ:                   state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_R: begin
                        aop_c   = 2'b10;
                        state_d = S_WB;
                    end
                    OP_I: begin
                        src_c   = 1'b1;
                        aop_c   = 2'b10;
                        state_d = S_WB;
                    end
                    OP_LD: begin
                        src_c   = 1'b1;
                        state_d = S_MEM_RD;
                    end
                    OP_SD: begin
                        src_c   = 1'b1;
                        state_d = S_MEM_WR;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM_RD: begin
                mrd_c = 1'b1;
                src_c = 1'b1;
                if (dmem_ready) state_d = S_WB;
            end
            S_MEM_WR: begin
                mwr_c = 1'b1;
                src_c = 1'b1;
                if (dmem_ready) begin
                    state_d = S_FETCH;
                    ret_d   = ret_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rw_c    = 1'b1;
                m2r_c   = (op_q == OP_LD);
                state_d = S_FETCH;
                ret_d   = ret_q + CNT_W'(1);
            end
            S_BRANCH: begin
                aop_c   = 2'b01;
                br_c    = 1'b1;
                state_d = S_FETCH;
                ret_d   = ret_q + CNT_W'(1);
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        if (waiting) wait_d = wait_q + 8'd1;
        if (expire) begin
            state_d = S_TRAP;
            to_d    = 1'b1;
        end
        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM_RD ||
             state_d == S_MEM_WR))
            wait_d = 8'd0;
    end

    assign imem_req   = req_c & ~kill;
    assign ir_write   = irw_c & ~kill;
    assign pc_write   = pcw_c & ~kill;
    assign alu_src    = src_c & ~kill;
    assign alu_op     = aop_c & {2{~kill}};
    assign mem_read   = mrd_c & ~kill;
    assign mem_write  = mwr_c & ~kill;
    assign mem_to_reg = m2r_c & ~kill;
    assign reg_write  = rw_c & ~kill;
    assign branch     = br_c & ~kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            ret_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            ret_q   <= ret_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    assign illegal   = ill_q;
    assign timeout   = to_q;
    assign state_dbg = state_q;
    assign retired   = ret_q;

endmodule
